// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC time/date edit controllers.
// Holds the edit FSM state encoding, BCD constants used by the day
// controller and the BCD codes of the 30-day months.
package rtc_pkg;

   // Edit FSM states, 2-bit binary encoding.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_EDIT   = 2'd2,
      ST_COMMIT = 2'd3
   } edit_state_t;

   // BCD constants.
   localparam logic [7:0] DIA_MIN = 8'h01;
   localparam logic [7:0] FEB     = 8'h02;

   // Months with 30 days (BCD).
   localparam logic [7:0] ABR = 8'h04;
   localparam logic [7:0] JUN = 8'h06;
   localparam logic [7:0] SEP = 8'h09;
   localparam logic [7:0] NOV = 8'h11;

   // True when both nibbles of a packed BCD byte are decimal digits.
   function automatic logic bcd_valid(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

endpackage

// File: rtl/dias_mes.sv
// Days-in-month lookup (combinational).
// Ports:
//   mes     in  8  month in BCD (01..12; anything else counts as a 31-day month)
//   anio    in  8  year in BCD (00..99 meaning 2000..2099)
//   max_dia out 8  number of days in that month, in BCD
// Leap years are years divisible by 4; within 2000..2099 that is exact.
module dias_mes
   import rtc_pkg::*;
(
   input  logic [7:0] mes,
   input  logic [7:0] anio,
   output logic [7:0] max_dia
);

   logic bisiesto;

   // Divisibility by 4 from the two BCD digits: 10*T + U is a multiple of 4
   // when T is even and U is 0/4/8, or T is odd and U is 2/6.
   always_comb begin
      bisiesto = 1'b0;
      if (anio[4]) begin
         bisiesto = (anio[3:0] == 4'd2) || (anio[3:0] == 4'd6);
      end else begin
         bisiesto = (anio[3:0] == 4'd0) || (anio[3:0] == 4'd4) ||
                    (anio[3:0] == 4'd8);
      end
   end

   always_comb begin
      max_dia = 8'h31;
      if (mes == FEB) begin
         max_dia = bisiesto ? 8'h29 : 8'h28;
      end else if ((mes == ABR) || (mes == JUN) || (mes == SEP) || (mes == NOV)) begin
         max_dia = 8'h30;
      end
   end

endmodule

// File: rtl/dia_edit_ctrl.sv
// Day-of-month edit controller.
// While the day field is selected it loads the current day, steps it up or
// down in BCD with month/leap-year aware wrap-around, and commits the result
// to the day register with a single-cycle write strobe.
// Ports:
//   clk        in  1  system clock
//   reset      in  1  synchronous active-low reset
//   edit_mode  in  1  day field selected (level)
//   btn_up     in  1  increment pulse
//   btn_dn     in  1  decrement pulse
//   mes        in  8  current month (BCD)
//   anio       in  8  current year (BCD)
//   dia_actual in  8  day currently held in the day register (BCD)
//   ddia       out 8  day value presented to the day register (BCD)
//   EN         out 1  day register write strobe, one cycle per commit
//   editando   out 1  high while loading/editing (blink indication)
// Handshake: EN is a one-cycle write strobe with ddia valid in the same
// cycle; the day register has no back-pressure, so there is no ready.
module dia_edit_ctrl
   import rtc_pkg::*;
#(
   parameter logic [7:0] DIA_RESET = 8'h01
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       edit_mode,
   input  logic       btn_up,
   input  logic       btn_dn,
   input  logic [7:0] mes,
   input  logic [7:0] anio,
   input  logic [7:0] dia_actual,
   output logic [7:0] ddia,
   output logic       EN,
   output logic       editando
);

   edit_state_t state;
   logic        em_q;     // registered edit_mode
   logic        em_prev;  // previous em_q, for rising-edge detection
   logic [7:0]  max_dia;
   logic [7:0]  dia_load;
   logic [7:0]  dia_inc;
   logic [7:0]  dia_dec;
   logic [7:0]  dia_clamp;

   dias_mes u_dias_mes (
      .mes     (mes),
      .anio    (anio),
      .max_dia (max_dia)
   );

   // Normalised load value: garbage or zero becomes 01, too large clamps.
   always_comb begin
      dia_load = dia_actual;
      if (!bcd_valid(dia_actual) || (dia_actual == 8'h00)) begin
         dia_load = DIA_MIN;
      end else if (dia_actual > max_dia) begin
         dia_load = max_dia;
      end
   end

   // BCD step, digit-wise on the two nibbles. For valid BCD bytes the packed
   // magnitude compare orders the same way as the decimal values.
   always_comb begin
      dia_inc = ddia;
      if (ddia == max_dia) begin
         dia_inc = DIA_MIN;
      end else if (ddia[3:0] == 4'd9) begin
         dia_inc = {ddia[7:4] + 4'd1, 4'd0};
      end else begin
         dia_inc = {ddia[7:4], ddia[3:0] + 4'd1};
      end
   end

   always_comb begin
      dia_dec = ddia;
      if (ddia == DIA_MIN) begin
         dia_dec = max_dia;
      end else if (ddia[3:0] == 4'd0) begin
         dia_dec = {ddia[7:4] - 4'd1, 4'd9};
      end else begin
         dia_dec = {ddia[7:4], ddia[3:0] - 4'd1};
      end
   end

   // Month or year may have changed during the edit.
   always_comb begin
      dia_clamp = (ddia > max_dia) ? max_dia : ddia;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= ST_IDLE;
         em_q     <= 1'b0;
         em_prev  <= 1'b0;
         ddia     <= DIA_RESET;
         EN       <= 1'b0;
         editando <= 1'b0;
      end else begin
         em_q     <= edit_mode;
         em_prev  <= em_q;
         EN       <= 1'b0;
         editando <= (state == ST_LOAD) || (state == ST_EDIT);
         case (state)
            ST_IDLE: begin
               if (em_q && !em_prev) begin
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               ddia  <= dia_load;
               state <= ST_EDIT;
            end
            ST_EDIT: begin
               if (!em_q) begin
                  // EN and the clamped value appear together in COMMIT.
                  ddia  <= dia_clamp;
                  EN    <= 1'b1;
                  state <= ST_COMMIT;
               end else if (btn_up && !btn_dn) begin
                  ddia <= dia_inc;
               end else if (btn_dn && !btn_up) begin
                  ddia <= dia_dec;
               end
            end
            ST_COMMIT: begin
               // Forget the edge history so a re-assertion during COMMIT
               // is still seen as a rising edge once back in IDLE.
               em_prev <= 1'b0;
               state   <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dia_edit_ctrl.sv
// Self-checking bench for dia_edit_ctrl: a cycle model built from the
// day/month/leap-year rules on plain integers, compared every cycle, plus
// directed scenarios with literal expectations.
module tb_dia_edit_ctrl;

   logic       clk;
   logic       reset;
   logic       edit_mode;
   logic       btn_up;
   logic       btn_dn;
   logic [7:0] mes;
   logic [7:0] anio;
   logic [7:0] dia_actual;
   logic [7:0] ddia;
   logic       EN;
   logic       editando;

   int checks = 0;
   int errors = 0;

   dia_edit_ctrl #(.DIA_RESET(8'h01)) dut (
      .clk        (clk),
      .reset      (reset),
      .edit_mode  (edit_mode),
      .btn_up     (btn_up),
      .btn_dn     (btn_dn),
      .mes        (mes),
      .anio       (anio),
      .dia_actual (dia_actual),
      .ddia       (ddia),
      .EN         (EN),
      .editando   (editando)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   function automatic int bcd_to_int(input logic [7:0] v);
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [7:0] int_to_bcd(input int n);
      logic [7:0] r;
      r[7:4] = 4'(n / 10);
      r[3:0] = 4'(n % 10);
      return r;
   endfunction

   function automatic int model_max(input logic [7:0] m, input logic [7:0] a);
      int mi;
      int yi;
      if (m[7:4] > 4'd9 || m[3:0] > 4'd9) return 31;
      mi = bcd_to_int(m);
      yi = 2000 + bcd_to_int(a);
      if (mi == 2) return (yi % 4 == 0) ? 29 : 28;
      if (mi == 4 || mi == 6 || mi == 9 || mi == 11) return 30;
      return 31;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 loading, 2 editing, 3 committing
   int   m_phase;
   int   m_old;
   int   m_day;
   int   m_mx;
   int   m_n;
   logic m_en;
   logic m_edit;
   logic m_seen;
   logic m_seen_d;
   logic model_ready = 1'b0;

   always @(posedge clk) begin
      model_ready = 1'b1;
      if (!reset) begin
         m_phase  = 0;
         m_day    = 1;
         m_en     = 1'b0;
         m_edit   = 1'b0;
         m_seen   = 1'b0;
         m_seen_d = 1'b0;
      end else begin
         m_mx   = model_max(mes, anio);
         m_old  = m_phase;
         m_edit = (m_phase == 1) || (m_phase == 2);
         m_en   = 1'b0;
         case (m_phase)
            0: if (m_seen && !m_seen_d) m_phase = 1;
            1: begin
               if (dia_actual[7:4] > 4'd9 || dia_actual[3:0] > 4'd9) begin
                  m_day = 1;
               end else begin
                  m_n   = bcd_to_int(dia_actual);
                  m_day = (m_n == 0) ? 1 : ((m_n > m_mx) ? m_mx : m_n);
               end
               m_phase = 2;
            end
            2: begin
               if (!m_seen) begin
                  m_phase = 3;
                  m_en    = 1'b1;
                  if (m_day > m_mx) m_day = m_mx;
               end else if (btn_up && !btn_dn) begin
                  m_day = (m_day == m_mx) ? 1 : m_day + 1;
               end else if (btn_dn && !btn_up) begin
                  m_day = (m_day == 1) ? m_mx : m_day - 1;
               end
            end
            default: m_phase = 0;
         endcase
         m_seen_d = (m_old == 3) ? 1'b0 : m_seen;
         m_seen   = edit_mode;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (model_ready) begin
         check("cyc_ddia", ddia, int_to_bcd(m_day));
         check("cyc_en", {7'b0, EN}, {7'b0, m_en});
         check("cyc_editando", {7'b0, editando}, {7'b0, m_edit});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic start_edit(input logic [7:0] d, input logic [7:0] m, input logic [7:0] a);
      dia_actual = d;
      mes        = m;
      anio       = a;
      edit_mode  = 1'b1;
      repeat (3) tick();
   endtask

   // Leaves the bench at the cycle where EN must be high.
   task automatic end_edit();
      edit_mode = 1'b0;
      repeat (2) tick();
   endtask

   task automatic press_up();
      btn_up = 1'b1;
      tick();
      btn_up = 1'b0;
   endtask

   task automatic press_dn();
      btn_dn = 1'b1;
      tick();
      btn_dn = 1'b0;
   endtask

   task automatic commit_expect(input string name, input logic [7:0] d);
      end_edit();
      check({name, "_en"}, {7'b0, EN}, 8'h01);
      check({name, "_ddia"}, ddia, d);
      tick();
      check({name, "_en_low"}, {7'b0, EN}, 8'h00);
      tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset      = 1'b0;
      edit_mode  = 1'b0;
      btn_up     = 1'b0;
      btn_dn     = 1'b0;
      mes        = 8'h01;
      anio       = 8'h24;
      dia_actual = 8'h15;
      repeat (2) tick();
      check("rst_ddia", ddia, 8'h01);
      check("rst_en", {7'b0, EN}, 8'h00);
      check("rst_editando", {7'b0, editando}, 8'h00);
      reset = 1'b1;
      repeat (2) tick();

      // Wrap up in a 30-day month.
      start_edit(8'h29, 8'h04, 8'h24);
      check("up_load", ddia, 8'h29);
      press_up();
      check("up_30", ddia, 8'h30);
      press_up();
      check("up_wrap", ddia, 8'h01);
      commit_expect("up_commit", 8'h01);

      // Wrap down in February, leap and non-leap years.
      start_edit(8'h01, 8'h02, 8'h24);
      press_dn();
      check("dn_leap", ddia, 8'h29);
      commit_expect("dn_leap_commit", 8'h29);
      start_edit(8'h01, 8'h02, 8'h23);
      press_dn();
      check("dn_noleap", ddia, 8'h28);
      commit_expect("dn_noleap_commit", 8'h28);
      start_edit(8'h01, 8'h02, 8'h96);
      press_dn();
      check("dn_leap96", ddia, 8'h29);
      commit_expect("dn_leap96_commit", 8'h29);
      start_edit(8'h01, 8'h02, 8'h10);
      press_dn();
      check("dn_noleap10", ddia, 8'h28);
      commit_expect("dn_noleap10_commit", 8'h28);
      start_edit(8'h01, 8'h11, 8'h24);
      press_dn();
      check("dn_nov", ddia, 8'h30);
      commit_expect("dn_nov_commit", 8'h30);

      // BCD carry and borrow.
      start_edit(8'h09, 8'h01, 8'h24);
      press_up();
      check("carry", ddia, 8'h10);
      press_dn();
      check("borrow", ddia, 8'h09);
      commit_expect("carry_commit", 8'h09);

      // Clamp at commit after the month changes mid-edit.
      start_edit(8'h31, 8'h01, 8'h24);
      check("clamp_load", ddia, 8'h31);
      mes  = 8'h02;
      anio = 8'h25;
      tick();
      commit_expect("clamp_commit", 8'h28);

      // Load normalisation.
      start_edit(8'h3A, 8'h01, 8'h24);
      check("load_nonbcd", ddia, 8'h01);
      commit_expect("nonbcd_commit", 8'h01);
      start_edit(8'h00, 8'h01, 8'h24);
      check("load_zero", ddia, 8'h01);
      commit_expect("zero_commit", 8'h01);
      start_edit(8'h31, 8'h04, 8'h24);
      check("load_clamp", ddia, 8'h30);
      commit_expect("load_clamp_commit", 8'h30);

      // Invalid month behaves as a 31-day month.
      start_edit(8'h31, 8'h13, 8'h24);
      check("badmes_load", ddia, 8'h31);
      press_up();
      check("badmes_wrap", ddia, 8'h01);
      press_dn();
      check("badmes_back", ddia, 8'h31);
      commit_expect("badmes_commit", 8'h31);

      // Both buttons together are ignored.
      start_edit(8'h15, 8'h05, 8'h24);
      btn_up = 1'b1;
      btn_dn = 1'b1;
      tick();
      btn_up = 1'b0;
      btn_dn = 1'b0;
      check("both_btn", ddia, 8'h15);
      commit_expect("both_commit", 8'h15);

      // Pulse during LOAD is dropped; pulse in the commit cycle is ignored.
      dia_actual = 8'h12;
      mes        = 8'h05;
      edit_mode  = 1'b1;
      repeat (2) tick();
      btn_up = 1'b1;
      tick();
      btn_up = 1'b0;
      check("load_drop", ddia, 8'h12);
      press_up();
      check("after_drop", ddia, 8'h13);
      edit_mode = 1'b0;
      tick();
      btn_up = 1'b1;
      tick();
      btn_up = 1'b0;
      check("commit_pulse_en", {7'b0, EN}, 8'h01);
      check("commit_pulse_ddia", ddia, 8'h13);
      repeat (2) tick();

      // edit_mode re-asserted during COMMIT starts a new edit.
      start_edit(8'h20, 8'h05, 8'h24);
      dia_actual = 8'h07;
      edit_mode  = 1'b0;
      tick();
      edit_mode = 1'b1;
      tick();
      check("reassert_en", {7'b0, EN}, 8'h01);
      check("reassert_ddia", ddia, 8'h20);
      repeat (3) tick();
      check("reassert_reload", ddia, 8'h07);
      check("reassert_editando", {7'b0, editando}, 8'h01);
      commit_expect("reassert_commit", 8'h07);

      // Reset in the middle of an edit: no commit.
      start_edit(8'h05, 8'h05, 8'h24);
      press_up();
      check("pre_reset", ddia, 8'h06);
      reset     = 1'b0;
      edit_mode = 1'b0;
      repeat (2) tick();
      check("midrst_ddia", ddia, 8'h01);
      check("midrst_en", {7'b0, EN}, 8'h00);
      check("midrst_editando", {7'b0, editando}, 8'h00);
      reset = 1'b1;
      repeat (4) tick();
      check("post_rst_en", {7'b0, EN}, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dia_edit_ctrl.md
# dia_edit_ctrl

User-edit controller for the day-of-month field of the RTC time/date datapath. While the day field is selected for editing, it steps a BCD day value up or down with month- and leap-year-aware wrap-around. It commits the result to the downstream day register through its data/enable pair (`ddia`, `EN`). It sits between the debounced button logic / field-select FSM and the day register.

## Interface
Parameters:
- `DIA_RESET`, 8'h01: BCD day value driven on `ddia` after reset.

Ports:
- `clk`, in, 1: system clock. One clock domain.
- `reset`, in, 1: synchronous, active-low reset. It is sampled on the rising edge of `clk`.
- `edit_mode`, in, 1: high while the day field is selected. Level input from the field-select FSM.
- `btn_up`, in, 1: debounced single-cycle increment pulse.
- `btn_dn`, in, 1: debounced single-cycle decrement pulse.
- `mes`, in, 8: current month in BCD, 8'h01..8'h12.
- `anio`, in, 8: current year in BCD, 8'h00..8'h99, meaning 2000–2099.
- `dia_actual`, in, 8: day value currently held in the day register, in BCD.
- `ddia`, out, 8: BCD day value presented to the day register.
- `EN`, out, 1: write strobe to the day register. Asserted for exactly one cycle per commit.
- `editando`, out, 1: high while the block is in LOAD or EDIT. Drives the blink indication.

## Operation
- Days-in-month (`max_dia`), combinational:
  - Month 02: 8'h29 if leap year, else 8'h28.
  - Months 04, 06, 09, 11: 8'h30.
  - All other months: 8'h31, including invalid `mes` (00, >12, or a non-BCD nibble).
- Leap year: `anio` divisible by 4. With tens digit T and units digit U:
  - T even and U ∈ {0,4,8}, or
  - T odd and U ∈ {2,6}.
- FSM states: IDLE, LOAD, EDIT, COMMIT. Encoding is binary, 2 bits.
  - IDLE: `edit_mode` is registered, and a rising edge of the registered value moves to LOAD. `ddia` holds its value.
  - LOAD, one cycle: `ddia` takes `dia_actual`, normalised as follows, then the FSM moves to EDIT.
    - 8'h00 or any non-BCD nibble becomes 8'h01.
    - A value greater than `max_dia` becomes `max_dia`.
  - EDIT:
    - `btn_up` only: if `ddia` == `max_dia`, go to 8'h01; otherwise BCD increment (units 9 → 0 with carry to tens).
    - `btn_dn` only: if `ddia` == 8'h01, go to `max_dia`; otherwise BCD decrement (units 0 → 9 with borrow from tens).
    - Both buttons in the same cycle: ignored.
    - `edit_mode` low moves to COMMIT, even in a cycle with a button pulse; that pulse is ignored.
  - COMMIT, one cycle: `EN` = 1.
    - `ddia` is re-clamped to `max_dia`, because `mes`/`anio` may have changed during the edit. The clamped value appears in the same cycle `EN` is high.
    - The FSM then moves to IDLE.
- BCD arithmetic is digit-wise on two 4-bit nibbles. No binary add is allowed on the packed byte.
- `EN` is registered and never asserted outside COMMIT.

## Timing
- Reset values: state = IDLE, `ddia` = `DIA_RESET`, `EN` = 0, `editando` = 0, edit_mode register = 0.
- Reset mid-edit: the block returns to IDLE with no `EN` pulse and no commit.
- `edit_mode` rise to LOAD: 2 cycles (1 cycle for the input register, 1 cycle to detect the edge).
- LOAD to EDIT: 1 cycle. Button pulses that arrive during LOAD are dropped.
- In EDIT, a pulse at edge n produces the updated `ddia` visible after edge n+1. The block accepts one step per cycle.
- Fall of the registered `edit_mode` to `EN` high: 1 cycle. `EN` stays high for 1 cycle only.
- `editando` is registered and follows the state with 1 cycle latency.
- `edit_mode` re-asserted during COMMIT: the IDLE edge detector sees it on the next cycle, and a new LOAD follows.

## Structure
- Shared package `rtc_pkg` holds:
  - FSM state constants.
  - BCD constants DIA_MIN = 8'h01 and FEB = 8'h02.
  - The month constants for 30-day months.
- Sub-module `dias_mes`: combinational, with inputs `mes` and `anio` and output `max_dia`. Computes the leap-year rule and the days-in-month table. It is reused by the month/year edit controllers.
- The top level contains the FSM, the BCD step logic and the output registers.

## Test plan
- Reset: drive `reset` = 0 for 2 cycles → `ddia` = 8'h01, `EN` = 0, `editando` = 0.
- Wrap up: `mes` = 8'h04, `dia_actual` = 8'h29, edit, 2× `btn_up` → `ddia` 8'h30 then 8'h01; drop `edit_mode` → one `EN` pulse with `ddia` = 8'h01.
- Wrap down: `mes` = 8'h02, `anio` = 8'h24, load 8'h01, 1× `btn_dn` → 8'h29. Repeat with `anio` = 8'h23 → 8'h28.
- BCD carry: load 8'h09, `btn_up` → 8'h10; `btn_dn` → 8'h09.
- Clamp: load 8'h31 with `mes` = 8'h01; change `mes` to 8'h02 and `anio` to 8'h25 during EDIT; commit → `EN` high with `ddia` = 8'h28. Load with `dia_actual` = 8'h3A → `ddia` = 8'h01.
- Edge cases: `btn_up` and `btn_dn` together → `ddia` unchanged. Reset asserted during EDIT → no `EN` pulse, back to reset values.
